// File: rtl/iob_eth_bd_pkg.sv
// Shared definitions for the multi-queue Ethernet buffer-descriptor scheduler.
// Holds the BD word0 field positions, the scheduler FSM encoding and the
// queue-index width helper used by the scheduler and its arbiter.
package iob_eth_bd_pkg;

  // BD word0 layout: [31:16] LEN, [15] READY, [14] IRQ, [13] WRAP, [8:0] STATUS
  localparam int W0_LEN_LSB  = 16;
  localparam int W0_LEN_W    = 16;
  localparam int W0_READY    = 15;
  localparam int W0_IRQ      = 14;
  localparam int W0_WRAP     = 13;
  localparam int W0_STATUS_W = 9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARB   = 3'd1,
    ST_RD0   = 3'd2,
    ST_RD1   = 3'd3,
    ST_CHK   = 3'd4,
    ST_ISSUE = 3'd5,
    ST_WAIT  = 3'd6,
    ST_WB    = 3'd7
  } bd_state_e;

  // Queue index width; a single queue still needs one bit to carry a job tag.
  function automatic int q_width(input int n_q);
    return (n_q <= 1) ? 1 : $clog2(n_q);
  endfunction

endpackage

// File: rtl/iob_eth_rr_arb.sv
// Round-robin arbiter with a last-grant register.
// The search starts at the queue after the last granted one, so a queue that
// was just served has the lowest priority on the next round.
// Ports:
//   clk_i, cke_i, rst_i : clock, clock enable, synchronous active-high reset
//   req_i               : per-queue request
//   adv_i               : commit the current grant as the new last grant
//   gnt_valid_o         : at least one request present
//   gnt_o               : index of the granted queue
module iob_eth_rr_arb
  import iob_eth_bd_pkg::*;
#(
  parameter  int N_Q = 4,
  localparam int Q_W = q_width(N_Q)
) (
  input  logic           clk_i,
  input  logic           cke_i,
  input  logic           rst_i,
  input  logic [N_Q-1:0] req_i,
  input  logic           adv_i,
  output logic           gnt_valid_o,
  output logic [Q_W-1:0] gnt_o
);

  logic [Q_W-1:0] last_q, last_d;

  // Scan from the farthest offset down so the nearest requester after
  // last_q is the one left standing.
  always_comb begin
    int             cand;
    logic [Q_W-1:0] cand_idx;
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned (which would infer a latch).
    gnt_valid_o = 1'b0;
    gnt_o       = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int off = N_Q; off >= 1; off--) begin
      cand     = (int'(last_q) + off) % N_Q;
      cand_idx = Q_W'(cand);
      if (req_i[cand_idx]) begin
        gnt_valid_o = 1'b1;
        gnt_o       = cand_idx;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (adv_i && gnt_valid_o) last_d = gnt_o;
  end

  // Reset to the highest index so queue 0 is first after reset.
  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so all flops
    // sample the pre-edge values regardless of evaluation order.
    if (rst_i)      last_q <= Q_W'(N_Q - 1);
    else if (cke_i) last_q <= last_d;
  end

endmodule

// File: rtl/iob_eth_bd_sched.sv
// Multi-queue buffer-descriptor scheduler for the Ethernet DMA path.
// Walks N_Q descriptor rings in the shared BD RAM, round-robins between
// queues, hands one frame job at a time to the DMA and writes completion
// status back into word0. Per-queue interrupts support masking and
// completion coalescing.
// Ports:
//   clk_i/cke_i/rst_i   : clock, clock enable, synchronous active-high reset
//   en_i, q_en_i        : global / per-queue enable
//   q_base_i            : packed ring base BD index per queue
//   kick_i              : software readied BDs on a queue
//   bd_*                : BD RAM port (read data valid one cycle after read)
//   job_*               : job offer to the DMA (valid/ready)
//   done_valid_i/status : DMA completion of the current job
//   coal_thr_i          : per-queue coalescing threshold (0 behaves as 1)
//   irq_mask_i/ack_i    : per-queue interrupt mask and clear
//   irq_o/irq_any_o     : per-queue interrupt and their OR
//   cur_idx_o, busy_o   : current BD index per queue, FSM not idle
module iob_eth_bd_sched
  import iob_eth_bd_pkg::*;
#(
  parameter  int N_Q         = 4,
  parameter  int BD_NUM_LOG2 = 7,
  parameter  int COAL_W      = 4,
  localparam int Q_W         = q_width(N_Q)
) (
  input  logic                       clk_i,
  input  logic                       cke_i,
  input  logic                       rst_i,
  input  logic                       en_i,
  input  logic [N_Q-1:0]             q_en_i,
  input  logic [N_Q*BD_NUM_LOG2-1:0] q_base_i,
  input  logic [N_Q-1:0]             kick_i,
  output logic                       bd_en_o,
  output logic                       bd_wen_o,
  output logic [BD_NUM_LOG2:0]       bd_addr_o,
  output logic [31:0]                bd_wdata_o,
  input  logic [31:0]                bd_rdata_i,
  output logic                       job_valid_o,
  input  logic                       job_ready_i,
  output logic [Q_W-1:0]             job_q_o,
  output logic [15:0]                job_len_o,
  output logic [31:0]                job_ptr_o,
  input  logic                       done_valid_i,
  input  logic [8:0]                 done_status_i,
  input  logic [N_Q*COAL_W-1:0]      coal_thr_i,
  input  logic [N_Q-1:0]             irq_mask_i,
  input  logic [N_Q-1:0]             irq_ack_i,
  output logic [N_Q-1:0]             irq_o,
  output logic                       irq_any_o,
  output logic [N_Q*BD_NUM_LOG2-1:0] cur_idx_o,
  output logic                       busy_o
);

  bd_state_e               state_q, state_d;
  logic [Q_W-1:0]          q_sel_q, q_sel_d;
  logic [31:0]             w0_q, w0_d, w1_q, w1_d;
  logic [8:0]              status_q, status_d;
  logic [BD_NUM_LOG2-1:0]  cur_idx_q [N_Q];
  logic [BD_NUM_LOG2-1:0]  cur_idx_d [N_Q];
  logic [COAL_W-1:0]       cnt_q [N_Q];
  logic [COAL_W-1:0]       cnt_d [N_Q];
  logic [N_Q-1:0]          pending_q, pending_d, irq_pend_q, irq_pend_d;

  logic [N_Q-1:0]          req;
  logic                    gnt_valid;
  logic [Q_W-1:0]          gnt;
  logic [BD_NUM_LOG2-1:0]  idx, base_sel;
  logic [COAL_W-1:0]       thr_sel, thr_eff;
  logic [COAL_W:0]         cnt_inc;

  assign req = pending_q & q_en_i;

  iob_eth_rr_arb #(.N_Q(N_Q)) u_arb (
    .clk_i       (clk_i),
    .cke_i       (cke_i),
    .rst_i       (rst_i),
    .req_i       (req),
    .adv_i       (state_q == ST_ARB),
    .gnt_valid_o (gnt_valid),
    .gnt_o       (gnt)
  );

  // Fields of the queue currently being served.
  always_comb begin
    idx      = cur_idx_q[q_sel_q];
    base_sel = q_base_i[int'(q_sel_q)*BD_NUM_LOG2 +: BD_NUM_LOG2];
    thr_sel  = coal_thr_i[int'(q_sel_q)*COAL_W +: COAL_W];
    thr_eff  = (thr_sel == '0) ? COAL_W'(1) : thr_sel;
    cnt_inc  = {1'b0, cnt_q[q_sel_q]} + 1'b1;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (en_i && |req) state_d = ST_ARB;
      ST_ARB:   state_d = gnt_valid ? ST_RD0 : ST_IDLE;
      ST_RD0:   state_d = ST_RD1;
      ST_RD1:   state_d = ST_CHK;
      ST_CHK:   state_d = w0_q[W0_READY] ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: if (job_ready_i) state_d = ST_WAIT;
      ST_WAIT:  if (done_valid_i) state_d = ST_WB;
      ST_WB:    state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath and per-queue bookkeeping.
  always_comb begin
    q_sel_d    = q_sel_q;
    w0_d       = w0_q;
    w1_d       = w1_q;
    status_d   = status_q;
    cur_idx_d  = cur_idx_q;
    cnt_d      = cnt_q;
    pending_d  = pending_q;
    // Ack clears first; any set below overrides it in the same cycle.
    irq_pend_d = irq_pend_q & ~irq_ack_i;
    case (state_q)
      ST_ARB:  if (gnt_valid) q_sel_d = gnt;
      ST_RD1:  w0_d = bd_rdata_i;
      ST_CHK: begin
        w1_d = bd_rdata_i;
        if (!w0_q[W0_READY]) begin
          // Ring drained: stop polling and flush any partially coalesced count.
          pending_d[q_sel_q] = 1'b0;
          if (cnt_q[q_sel_q] != '0) begin
            irq_pend_d[q_sel_q] = 1'b1;
            cnt_d[q_sel_q]      = '0;
          end
        end
      end
      ST_WAIT: if (done_valid_i) status_d = done_status_i;
      ST_WB: begin
        // q_base is only re-read here, so a base change lands at the next wrap.
        cur_idx_d[q_sel_q] = (w0_q[W0_WRAP] || (&idx)) ? base_sel : idx + 1'b1;
        if (w0_q[W0_IRQ]) begin
          if (cnt_inc >= {1'b0, thr_eff}) begin
            irq_pend_d[q_sel_q] = 1'b1;
            cnt_d[q_sel_q]      = '0;
          end else begin
            cnt_d[q_sel_q] = cnt_inc[COAL_W] ? '1 : cnt_inc[COAL_W-1:0];
          end
        end
      end
      default: ;
    endcase
    // A kick coinciding with the drained-ring clear keeps the queue pending.
    pending_d = pending_d | kick_i;
  end

  // Output decode from the current state.
  always_comb begin
    bd_en_o     = 1'b0;
    bd_wen_o    = 1'b0;
    bd_addr_o   = '0;
    bd_wdata_o  = '0;
    job_valid_o = 1'b0;
    job_q_o     = '0;
    job_len_o   = '0;
    job_ptr_o   = '0;
    case (state_q)
      ST_RD0: begin
        bd_en_o   = 1'b1;
        bd_addr_o = {idx, 1'b0};
      end
      ST_RD1: begin
        bd_en_o   = 1'b1;
        bd_addr_o = {idx, 1'b1};
      end
      ST_ISSUE: begin
        job_valid_o = 1'b1;
        job_q_o     = q_sel_q;
        job_len_o   = w0_q[W0_LEN_LSB +: W0_LEN_W];
        job_ptr_o   = w1_q;
      end
      ST_WB: begin
        bd_en_o    = 1'b1;
        bd_wen_o   = 1'b1;
        bd_addr_o  = {idx, 1'b0};
        bd_wdata_o = {w0_q[31:16], 1'b0, w0_q[14:9], status_q};
      end
      default: ;
    endcase
  end

  always_comb begin
    for (int q = 0; q < N_Q; q++) cur_idx_o[q*BD_NUM_LOG2 +: BD_NUM_LOG2] = cur_idx_q[q];
  end

  assign irq_o     = irq_pend_q & ~irq_mask_i;
  assign irq_any_o = |irq_o;
  assign busy_o    = (state_q != ST_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      q_sel_q    <= '0;
      w0_q       <= '0;
      w1_q       <= '0;
      status_q   <= '0;
      pending_q  <= '0;
      irq_pend_q <= '0;
      // NOTE: these per-queue arrays are a handful of flops, not RAM, so they
      // are reset explicitly; the ring index loads its configured base.
      for (int q = 0; q < N_Q; q++) begin
        cur_idx_q[q] <= q_base_i[q*BD_NUM_LOG2 +: BD_NUM_LOG2];
        cnt_q[q]     <= '0;
      end
    end else if (cke_i) begin
      state_q    <= state_d;
      q_sel_q    <= q_sel_d;
      w0_q       <= w0_d;
      w1_q       <= w1_d;
      status_q   <= status_d;
      pending_q  <= pending_d;
      irq_pend_q <= irq_pend_d;
      cur_idx_q  <= cur_idx_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_iob_eth_bd_sched.sv
module tb_iob_eth_bd_sched;

  localparam int N_Q = 4;
  localparam int BDL = 7;
  localparam int CW  = 4;
  localparam logic [31:0] RDY = 32'h0000_8000;
  localparam logic [31:0] IRQ = 32'h0000_4000;
  localparam logic [31:0] WRP = 32'h0000_2000;
  localparam logic [27:0] BASES = {7'd32, 7'd16, 7'd4, 7'd0};

  logic              clk_i = 1'b0;
  logic              cke_i, rst_i, en_i;
  logic [N_Q-1:0]    q_en_i, kick_i, irq_mask_i, irq_ack_i, irq_o;
  logic [N_Q*BDL-1:0] q_base_i, cur_idx_o;
  logic              bd_en_o, bd_wen_o;
  logic [BDL:0]      bd_addr_o;
  logic [31:0]       bd_wdata_o, bd_rdata_i;
  logic              job_valid_o, job_ready_i;
  logic [1:0]        job_q_o;
  logic [15:0]       job_len_o;
  logic [31:0]       job_ptr_o;
  logic              done_valid_i;
  logic [8:0]        done_status_i;
  logic [N_Q*CW-1:0] coal_thr_i;
  logic              irq_any_o, busy_o;

  always #5 clk_i = ~clk_i;

  iob_eth_bd_sched #(.N_Q(N_Q), .BD_NUM_LOG2(BDL), .COAL_W(CW)) dut (
    .clk_i(clk_i), .cke_i(cke_i), .rst_i(rst_i), .en_i(en_i), .q_en_i(q_en_i),
    .q_base_i(q_base_i), .kick_i(kick_i), .bd_en_o(bd_en_o), .bd_wen_o(bd_wen_o),
    .bd_addr_o(bd_addr_o), .bd_wdata_o(bd_wdata_o), .bd_rdata_i(bd_rdata_i),
    .job_valid_o(job_valid_o), .job_ready_i(job_ready_i), .job_q_o(job_q_o),
    .job_len_o(job_len_o), .job_ptr_o(job_ptr_o), .done_valid_i(done_valid_i),
    .done_status_i(done_status_i), .coal_thr_i(coal_thr_i), .irq_mask_i(irq_mask_i),
    .irq_ack_i(irq_ack_i), .irq_o(irq_o), .irq_any_o(irq_any_o),
    .cur_idx_o(cur_idx_o), .busy_o(busy_o)
  );

  // BD RAM model: one-cycle read latency, plus a bench-side write/clear port.
  logic [31:0] mem [256];
  logic        tb_we, tb_clr;
  logic [7:0]  tb_addr;
  logic [31:0] tb_wdata;

  always @(posedge clk_i) begin
    if (tb_clr) for (int i = 0; i < 256; i++) mem[i] <= '0;
    else if (tb_we) mem[tb_addr] <= tb_wdata;
    if (bd_en_o) begin
      if (bd_wen_o) mem[bd_addr_o] <= bd_wdata_o;
      else          bd_rdata_i <= mem[bd_addr_o];
    end
  end

  typedef struct packed {
    logic [1:0]  q;
    logic [15:0] len;
    logic [31:0] ptr;
  } job_t;

  job_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_bd(input int idx, input logic [31:0] w0, input logic [31:0] w1);
    tb_we = 1'b1; tb_addr = 8'(2*idx);   tb_wdata = w0; tick();
    tb_addr = 8'(2*idx+1); tb_wdata = w1; tick();
    tb_we = 1'b0;
  endtask

  task automatic expect_job(input logic [1:0] q, input logic [15:0] len, input logic [31:0] ptr);
    job_t e;
    e.q = q; e.len = len; e.ptr = ptr;
    sb.push_back(e);
  endtask

  task automatic kick(input logic [N_Q-1:0] m);
    kick_i = m; tick(); kick_i = '0;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Busy must stay low over the whole window.
  task automatic check_quiet(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      seen = seen | busy_o;
      tick();
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  task automatic take_job(output bit ok);
    job_t e;
    int   n;
    ok = 1'b0;
    n  = 0;
    while (job_valid_o !== 1'b1 && n < 60) begin tick(); n++; end
    check("job_valid", 32'(job_valid_o), 32'd1);
    if (job_valid_o !== 1'b1) return;
    check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check("job_q",   32'(job_q_o),   32'(e.q));
    check("job_len", 32'(job_len_o), 32'(e.len));
    check("job_ptr", job_ptr_o,      e.ptr);
    job_ready_i = 1'b1; tick(); job_ready_i = 1'b0;
    ok = 1'b1;
  endtask

  // Completes the accepted job; ack is driven during the write-back cycle.
  task automatic finish_job(input logic [8:0] st, input logic [N_Q-1:0] ack);
    tick();
    done_valid_i = 1'b1; done_status_i = st; tick();
    done_valid_i = 1'b0; done_status_i = '0;
    irq_ack_i = ack; tick(); irq_ack_i = '0;
  endtask

  task automatic serve(input logic [8:0] st, input logic [N_Q-1:0] ack);
    bit ok;
    take_job(ok);
    if (ok) finish_job(st, ack);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    cke_i = 1'b1; rst_i = 1'b1; en_i = 1'b1; q_en_i = '1; kick_i = '0;
    irq_mask_i = '0; irq_ack_i = '0; job_ready_i = 1'b0; done_valid_i = 1'b0;
    done_status_i = '0; coal_thr_i = '0; q_base_i = BASES;
    tb_we = 1'b0; tb_clr = 1'b1; tb_addr = '0; tb_wdata = '0;
    tick(); tb_clr = 1'b0; tick();
    check("rst_busy",    32'(busy_o),      32'd0);
    check("rst_job",     32'(job_valid_o), 32'd0);
    check("rst_bd_en",   32'(bd_en_o),     32'd0);
    check("rst_irq",     32'(irq_o),       32'd0);
    check("rst_cur_idx", 32'(cur_idx_o),   32'(BASES));
    rst_i = 1'b0; tick();

    // Single job on q0 with IRQ, threshold 0 acts as 1.
    set_bd(0, 32'h05DC_C000, 32'h0000_1000);
    expect_job(2'd0, 16'h05DC, 32'h1000);
    kick(4'b0001);
    serve(9'h005, '0);
    check("t1_wb_word0", mem[0], 32'h05DC_4005);
    check("t1_irq",      32'(irq_o), 32'h1);
    check("t1_cur_idx",  32'(cur_idx_o[6:0]), 32'd1);
    settle(10);
    check_quiet("t1_idle", 6);
    irq_ack_i = 4'b0001; tick(); irq_ack_i = '0;
    check("t1_ack", 32'(irq_o), 32'h0);

    // Ring wrap on q1.
    set_bd(4, 32'h0040_0000 | RDY,       32'h2000);
    set_bd(5, 32'h0080_0000 | RDY | WRP, 32'h3000);
    expect_job(2'd1, 16'h0040, 32'h2000);
    expect_job(2'd1, 16'h0080, 32'h3000);
    kick(4'b0010);
    serve(9'h011, '0);
    serve(9'h012, '0);
    check("t2_cur_idx", 32'(cur_idx_o[13:7]), 32'd4);
    check("t2_wb4",     mem[8],  32'h0040_0011);
    check("t2_wb5",     mem[10], 32'h0080_2012);
    settle(10);
    check_quiet("t2_drained", 8);

    // Round-robin across all queues from a fresh arbiter.
    rst_i = 1'b1; tick(); rst_i = 1'b0; tick();
    for (int q = 0; q < N_Q; q++) begin
      set_bd(int'(BASES[q*7 +: 7]),     ((32'h100 + q) << 16) | RDY, 32'hA000 + q);
      set_bd(int'(BASES[q*7 +: 7]) + 1, ((32'h200 + q) << 16) | RDY, 32'hB000 + q);
    end
    for (int r = 0; r < 2; r++)
      for (int q = 0; q < N_Q; q++)
        expect_job(2'(q), 16'(32'h100 * (r + 1) + q), 32'hA000 + 32'h1000 * r + q);
    kick(4'b1111);
    for (int j = 0; j < 8; j++) serve(9'(j), '0);
    check("t3_cur_idx", 32'(cur_idx_o), 32'({7'd34, 7'd18, 7'd6, 7'd2}));
    settle(25);
    check_quiet("t3_drained", 8);

    // Coalescing on q2 with threshold 3, then flush on the empty BD.
    coal_thr_i = 16'h0300;
    for (int i = 0; i < 5; i++) begin
      set_bd(18 + i, ((32'h300 + i) << 16) | RDY | IRQ, 32'hC000 + i);
      expect_job(2'd2, 16'(32'h300 + i), 32'hC000 + i);
    end
    kick(4'b0100);
    for (int i = 0; i < 5; i++) begin
      serve(9'h001, '0);
      if (i == 2) begin
        check("t4_coal_hit", 32'(irq_o[2]), 32'd1);
        irq_ack_i = 4'b0100; tick(); irq_ack_i = '0;
        check("t4_ack", 32'(irq_o[2]), 32'd0);
      end else begin
        check("t4_coal_wait", 32'(irq_o[2]), 32'd0);
      end
    end
    settle(10);
    check("t4_flush", 32'(irq_o[2]), 32'd1);
    irq_ack_i = 4'b0100; tick(); irq_ack_i = '0;
    check("t4_flush_ack", 32'(irq_any_o), 32'd0);

    // Global enable low blocks new arbitration.
    en_i = 1'b0;
    set_bd(34, 32'h0050_0000 | RDY, 32'hD000);
    expect_job(2'd3, 16'h0050, 32'hD000);
    kick(4'b1000);
    check_quiet("t5_en_off", 12);
    en_i = 1'b1;
    serve(9'h000, '0);
    check("t5_en_idx", 32'(cur_idx_o[27:21]), 32'd35);
    settle(10);

    // Masking hides but keeps the pending interrupt; set beats ack.
    irq_mask_i = 4'b0001;
    set_bd(2, 32'h0010_0000 | RDY | IRQ, 32'h4000);
    expect_job(2'd0, 16'h0010, 32'h4000);
    kick(4'b0001);
    serve(9'h000, '0);
    check("t5_masked",     32'(irq_o[0]),  32'd0);
    check("t5_masked_any", 32'(irq_any_o), 32'd0);
    irq_mask_i = '0; #1;
    check("t5_unmasked", 32'(irq_o[0]), 32'd1);
    settle(10);
    set_bd(3, 32'h0011_0000 | RDY | IRQ, 32'h4100);
    expect_job(2'd0, 16'h0011, 32'h4100);
    kick(4'b0001);
    serve(9'h000, 4'b0001);
    check("t5_ack_race", 32'(irq_o[0]), 32'd1);
    settle(10);
    irq_ack_i = 4'b0001; tick(); irq_ack_i = '0;
    check("t5_ack_clear", 32'(irq_o[0]), 32'd0);

    // Reset while waiting for completion; a late done is ignored.
    set_bd(6, 32'h0040_0000 | RDY, 32'h6000);
    expect_job(2'd1, 16'h0040, 32'h6000);
    kick(4'b0010);
    take_job(ok);
    tick();
    check("t6_in_wait", 32'(busy_o), 32'd1);
    rst_i = 1'b1; tick();
    check("t6_rst_busy",    32'(busy_o),      32'd0);
    check("t6_rst_job",     32'(job_valid_o), 32'd0);
    check("t6_rst_bd_en",   32'(bd_en_o),     32'd0);
    check("t6_rst_irq",     32'(irq_o),       32'd0);
    check("t6_rst_cur_idx", 32'(cur_idx_o),   32'(BASES));
    rst_i = 1'b0;
    done_valid_i = 1'b1; done_status_i = 9'h1FF; tick();
    done_valid_i = 1'b0; done_status_i = '0;
    check_quiet("t6_late_done", 6);
    check("t6_bd_untouched", mem[12], 32'h0040_8000);
    check("t6_sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iob_eth_bd_sched.md
Name: iob_eth_bd_sched

Overview:
- Multi-queue buffer-descriptor (BD) scheduler for the Ethernet DMA path; generalises the single TX/RX BD walk to N_Q independent descriptor rings.
- Walks each ring in the shared BD RAM and round-robins between queues. Hands one frame job at a time to the DMA/data mover, then writes back completion status.
- Per-queue interrupts support masking and completion coalescing.
- Sits between the CSR-visible BD RAM (port B) and iob_eth_dma.

Parameters:
- N_Q, 4, number of descriptor queues (1..8); Q_W = max(1, clog2(N_Q)).
- BD_NUM_LOG2, 7, log2 of BD count; BD RAM address width is BD_NUM_LOG2+1 (2 words per BD).
- COAL_W, 4, width of per-queue coalescing threshold/counter.

Ports:
- clk_i  in  1  clock
- cke_i  in  1  clock enable; all state holds when low
- rst_i  in  1  reset, synchronous, active-high
- en_i  in  1  global scheduler enable
- q_en_i  in  N_Q  per-queue enable
- q_base_i  in  N_Q*BD_NUM_LOG2  packed ring base BD index per queue
- kick_i  in  N_Q  pulse: software has readied BDs on queue q
- bd_en_o  out  1  BD RAM access enable
- bd_wen_o  out  1  BD RAM write enable
- bd_addr_o  out  BD_NUM_LOG2+1  word address = {idx,word}
- bd_wdata_o  out  32  write data
- bd_rdata_i  in  32  read data, valid 1 cycle after read
- job_valid_o  out  1  job offer to DMA
- job_ready_i  in  1  DMA accepts job
- job_q_o  out  Q_W  queue of job
- job_len_o  out  16  frame length (word0[31:16])
- job_ptr_o  out  32  buffer pointer (word1)
- done_valid_i  in  1  pulse: DMA finished current job
- done_status_i  in  9  status to write into word0[8:0]
- coal_thr_i  in  N_Q*COAL_W  per-queue threshold; 0 behaves as 1
- irq_mask_i  in  N_Q  1 = masked
- irq_ack_i  in  N_Q  pulse: clear queue interrupt
- irq_o  out  N_Q  per-queue interrupt
- irq_any_o  out  1  OR of irq_o
- cur_idx_o  out  N_Q*BD_NUM_LOG2  current BD index per queue
- busy_o  out  1  FSM not in IDLE

Behaviour:
- BD word0 layout: [31:16] LEN, [15] READY, [14] IRQ, [13] WRAP, [8:0] STATUS. Word1 is the buffer pointer. Word address = 2*idx + w.
- Reset values:
  - all outputs 0;
  - cur_idx[q] = q_base[q], sampled while rst_i is high;
  - pending, counters and irq pendings 0;
  - FSM in IDLE.
- pending[q]: set by kick_i[q]; cleared when a fetched BD has READY=0. A kick in the same cycle as the clear wins (pending stays 1).
- FSM states and transitions:
  - IDLE: if en_i and any (pending & q_en_i), go to ARB.
  - ARB: round-robin grant, starting after the last granted queue; latch q. Go to RD0.
  - RD0: read word0. Go to RD1.
  - RD1: capture word0; read word1. Go to CHK.
  - CHK: capture word1.
    - If READY=0: clear pending[q]; if cnt[q]>0, set irq_pend[q] and clear cnt[q] (flush). Go to IDLE.
    - Else go to ISSUE.
  - ISSUE: job_valid_o=1 with fields stable until job_ready_i. Go to WAIT.
  - WAIT: wait for done_valid_i; other done pulses are ignored in every other state. Go to WB.
  - WB: write word0 with READY=0, STATUS=done_status_i, other bits unchanged.
    - cur_idx[q] <= WRAP or idx all-ones ? q_base[q] : idx+1.
    - If IRQ bit set: cnt[q]++ (saturating); if cnt+1 >= max(thr,1), set irq_pend[q] and clear cnt.
    - Go to IDLE.
- Minimum BD-fetch-to-job_valid latency: 4 cycles after IDLE exit.
- en_i low: the in-flight job completes through WB; no new ARB.
- q_en_i low: queue skipped; index and pending held.
- irq_o = irq_pend & ~irq_mask_i; masking does not clear irq_pend.
- irq_ack_i clears irq_pend. If a new set occurs in the same cycle, the set wins.
- q_base change takes effect only at reset or at the next wrap.

Decomposition:
- Package iob_eth_bd_pkg holds:
  - word0 bit positions (LEN, READY, IRQ, WRAP, STATUS);
  - FSM state encoding;
  - Q_W function.
- One sub-module: iob_eth_rr_arb (N_Q-input round-robin arbiter with last-grant register).

Test Plan:
- Single queue, base 0, BD0 = LEN 0x05DC, READY, IRQ, ptr 0x1000; kick q0 -> job len 0x05DC, ptr 0x1000, q0. done status 0x005 -> word0 written 0x05DC4005. irq_o[0]=1 (thr 0), cur_idx 1.
- Ring wrap: q1 base 4, BDs 4,5 READY, BD5 WRAP -> jobs idx 4, 5. cur_idx returns to 4. BD4 now READY=0 -> pending cleared, FSM IDLE.
- Round-robin: q0..q3 all pending, each with 2 ready BDs -> job order q0,q1,q2,q3,q0,q1,q2,q3.
- Coalescing: thr=3, 5 IRQ BDs on q2 -> irq set after 3rd completion. Ack, then 2 more completions and an empty BD -> flush sets irq again.
- Mask/ack race: mask q0, complete IRQ BD -> irq_o[0]=0 while pending. Unmask -> irq_o[0]=1. Ack in the same cycle as a new set -> irq stays 1.
- rst_i asserted in WAIT -> next cycle all outputs 0, FSM IDLE, cur_idx = bases. Late done_valid_i ignored.
